// File: rtl/othello_pkg.sv
// -----------------------------------------------------------------------------
// othello_pkg
//   Shared definitions for the Othello board engine.
//   - cell codes (EMPTY, P_DARK, P_LIGHT)
//   - direction indices DIR_UP..DIR_UPL (clockwise from up)
//   - dir_dx / dir_dy : unit step of a direction, two's complement in 2 bits
//   - opponent()      : colour of the other player
//   - first_set()     : lowest set bit of a direction mask, {found, index}
//   - state_t         : engine FSM state encoding
// -----------------------------------------------------------------------------
package othello_pkg;

   localparam logic [1:0] EMPTY   = 2'd0;
   localparam logic [1:0] P_DARK  = 2'd2;
   localparam logic [1:0] P_LIGHT = 2'd3;

   localparam logic [2:0] DIR_UP  = 3'd0;
   localparam logic [2:0] DIR_UPR = 3'd1;
   localparam logic [2:0] DIR_R   = 3'd2;
   localparam logic [2:0] DIR_DNR = 3'd3;
   localparam logic [2:0] DIR_DN  = 3'd4;
   localparam logic [2:0] DIR_DNL = 3'd5;
   localparam logic [2:0] DIR_L   = 3'd6;
   localparam logic [2:0] DIR_UPL = 3'd7;

   // S_PUT is the final write of the mover's disc onto the target cell,
   // the closing cycle of the flip phase.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_SCAN  = 3'd2,
      S_FLIP  = 3'd3,
      S_PUT   = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   function automatic logic [1:0] opponent(input logic [1:0] s);
      return {1'b1, ~s[0]};
   endfunction

   // x step: +1 for the right-hand directions, -1 for the left-hand ones
   function automatic logic signed [1:0] dir_dx(input logic [2:0] d);
      case (d)
         DIR_UPR, DIR_R, DIR_DNR: return 2'sb01;
         DIR_DNL, DIR_L, DIR_UPL: return 2'sb11;
         default:                 return 2'sb00;
      endcase
   endfunction

   // y step: up is y-1
   function automatic logic signed [1:0] dir_dy(input logic [2:0] d);
      case (d)
         DIR_UPL, DIR_UP, DIR_UPR: return 2'sb11;
         DIR_DNR, DIR_DN, DIR_DNL: return 2'sb01;
         default:                  return 2'sb00;
      endcase
   endfunction

   // Scanned from the top down so the lowest set bit wins.
   function automatic logic [3:0] first_set(input logic [7:0] m);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) r = {1'b1, 3'(i)};
      end
      return r;
   endfunction

endpackage

// File: rtl/board_dir_stepper.sv
// -----------------------------------------------------------------------------
// board_dir_stepper
//   One step from (x, y) in direction d on an N x N board. Purely combinational.
//   Ports:
//     x, y      in  XW  current cell
//     d         in  3   direction index (othello_pkg DIR_*)
//     nx, ny    out XW  neighbour cell (meaningless when on_board = 0)
//     on_board  out 1   neighbour lies inside the board
//   Arithmetic is done two bits wider than the coordinates so that both
//   stepping below 0 and stepping to N are seen, for any N (power of two
//   or not).
// -----------------------------------------------------------------------------
module board_dir_stepper #(
   parameter int N  = 8,
   parameter int XW = $clog2(N)
) (
   input  logic [XW-1:0] x,
   input  logic [XW-1:0] y,
   input  logic [2:0]    d,
   output logic [XW-1:0] nx,
   output logic [XW-1:0] ny,
   output logic          on_board
);
   import othello_pkg::*;

   localparam logic signed [XW+1:0] NLIM = (XW+2)'(N);

   logic signed [1:0]    dx, dy;
   logic signed [XW+1:0] ddx, ddy;
   logic signed [XW+1:0] sx, sy;

   always_comb begin
      dx  = dir_dx(d);
      dy  = dir_dy(d);
      ddx = {{XW{dx[1]}}, dx};
      ddy = {{XW{dy[1]}}, dy};
      sx  = $signed({2'b00, x}) + ddx;
      sy  = $signed({2'b00, y}) + ddy;
      on_board = !sx[XW+1] && (sx < NLIM) && !sy[XW+1] && (sy < NLIM);
      nx = sx[XW-1:0];
      ny = sy[XW-1:0];
   end

endmodule

// File: rtl/board_engine.sv
// -----------------------------------------------------------------------------
// board_engine
//   Othello board store plus move engine. Checks all eight directions from a
//   target cell one board cell per clock, then (for PLACE) flips captured
//   discs one write per clock, counting them. A separate combinational read
//   port serves the display.
//   Ports:
//     clock, resetn             clock; synchronous active-low reset
//     cmd_valid / cmd_ready     command handshake
//     cmd_write                 0 = PROBE (check only), 1 = PLACE
//     side, x, y                mover colour and target, sampled at accept
//     done                      one-cycle pulse, results valid until next accept
//     legal, dir, flip_count    result of the last command
//     rd_x, rd_y, rd_q          display read port (combinational)
//     dbg_state                 current FSM state (othello_pkg::state_t)
//   Handshake: a command is accepted on a rising clock edge where cmd_valid
//   and cmd_ready are both 1. cmd_ready is 1 only while the engine is idle;
//   cmd_valid while cmd_ready is 0 is ignored and never queued, and the
//   command fields are only looked at on the accepting edge.
// -----------------------------------------------------------------------------
module board_engine #(
   parameter int N  = 8,
   parameter int XW = $clog2(N)
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [1:0]    side,
   input  logic [XW-1:0] x,
   input  logic [XW-1:0] y,
   output logic          done,
   output logic          legal,
   output logic [7:0]    dir,
   output logic [XW+2:0] flip_count,
   input  logic [XW-1:0] rd_x,
   input  logic [XW-1:0] rd_y,
   output logic [1:0]    rd_q,
   output logic [2:0]    dbg_state
);
   import othello_pkg::*;

   localparam int CELLS = N * N;
   localparam int AW    = $clog2(CELLS);
   localparam int H     = N / 2;

   function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] ax, input logic [XW-1:0] ay);
      int a;
      a = int'(ay) * N + int'(ax);
      return a[AW-1:0];
   endfunction

   logic [1:0]    board [CELLS];
   state_t        state;
   logic          wr_q;
   logic [1:0]    side_q;
   logic [XW-1:0] tx, ty;      // target cell
   logic [XW-1:0] cx, cy;      // walking cursor
   logic [2:0]    d;           // direction being scanned / flipped
   logic          first;       // cursor still on the target (first step pending)

   // cursor stepper: SCAN walk and FLIP walk
   logic [XW-1:0] sc_x, sc_y;
   logic          sc_on;
   // target stepper: first cell of the next direction to flip
   logic [XW-1:0] st_x, st_y;
   logic          st_on;

   logic [1:0] opp;
   logic [1:0] cell_next;
   logic       tgt_on;
   logic       scan_end, scan_hit;
   logic [7:0] dir_n;
   logic [7:0] sel_mask;
   logic       nd_found;
   logic [2:0] nd;

   board_dir_stepper #(.N(N), .XW(XW)) u_step_cur (
      .x(cx), .y(cy), .d(d), .nx(sc_x), .ny(sc_y), .on_board(sc_on)
   );

   board_dir_stepper #(.N(N), .XW(XW)) u_step_tgt (
      .x(tx), .y(ty), .d(nd), .nx(st_x), .ny(st_y), .on_board(st_on)
   );

   always_comb begin
      opp       = opponent(side_q);
      tgt_on    = (int'(tx) < N) && (int'(ty) < N);
      cell_next = sc_on ? board[cell_addr(sc_x, sc_y)] : EMPTY;

      // Direction outcome for this SCAN cycle. The first step must land on
      // an opponent disc; after that a run of opponent discs ends either on
      // the mover's disc (capture) or on anything else (no capture).
      scan_end = 1'b0;
      scan_hit = 1'b0;
      if (!sc_on) begin
         scan_end = 1'b1;
      end else if (first) begin
         scan_end = (cell_next != opp);
      end else if (cell_next != opp) begin
         scan_end = 1'b1;
         scan_hit = (cell_next == side_q);
      end
      dir_n = dir | (scan_hit ? (8'd1 << d) : 8'd0);

      // Next direction to flip: lowest captured one overall when leaving
      // SCAN, lowest captured one above d while already flipping.
      if (state == S_FLIP) sel_mask = dir & (8'hFE << d);
      else                 sel_mask = dir_n;
      {nd_found, nd} = first_set(sel_mask);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         for (int i = 0; i < CELLS; i++) board[i] <= EMPTY;
         board[cell_addr(XW'(H-1), XW'(H-1))] <= P_DARK;
         board[cell_addr(XW'(H),   XW'(H-1))] <= P_LIGHT;
         board[cell_addr(XW'(H-1), XW'(H))]   <= P_LIGHT;
         board[cell_addr(XW'(H),   XW'(H))]   <= P_DARK;
         state      <= S_IDLE;
         done       <= 1'b0;
         legal      <= 1'b0;
         dir        <= 8'd0;
         flip_count <= '0;
         wr_q       <= 1'b0;
         side_q     <= EMPTY;
         tx         <= '0;
         ty         <= '0;
         cx         <= '0;
         cy         <= '0;
         d          <= 3'd0;
         first      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  wr_q       <= cmd_write;
                  side_q     <= side;
                  tx         <= x;
                  ty         <= y;
                  dir        <= 8'd0;
                  legal      <= 1'b0;
                  flip_count <= '0;
                  state      <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (!tgt_on || board[cell_addr(tx, ty)] != EMPTY) begin
                  state <= S_FIN;
               end else begin
                  d     <= 3'd0;
                  cx    <= tx;
                  cy    <= ty;
                  first <= 1'b1;
                  state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (scan_end) begin
                  dir <= dir_n;
                  if (d == 3'd7) begin
                     if (wr_q && nd_found && st_on) begin
                        d     <= nd;
                        cx    <= st_x;
                        cy    <= st_y;
                        state <= S_FLIP;
                     end else begin
                        state <= S_FIN;
                     end
                  end else begin
                     d     <= d + 3'd1;
                     cx    <= tx;
                     cy    <= ty;
                     first <= 1'b1;
                  end
               end else begin
                  cx    <= sc_x;
                  cy    <= sc_y;
                  first <= 1'b0;
               end
            end
            S_FLIP: begin
               // cursor always sits on an opponent disc of a captured run
               board[cell_addr(cx, cy)] <= side_q;
               flip_count <= flip_count + (XW+3)'(1);
               if (sc_on && cell_next == opp) begin
                  cx <= sc_x;
                  cy <= sc_y;
               end else if (nd_found && st_on) begin
                  d  <= nd;
                  cx <= st_x;
                  cy <= st_y;
               end else begin
                  state <= S_PUT;
               end
            end
            S_PUT: begin
               board[cell_addr(tx, ty)] <= side_q;
               state <= S_FIN;
            end
            S_FIN: begin
               legal <= |dir;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready = (state == S_IDLE);
   assign dbg_state = state;
   assign rd_q      = ((int'(rd_x) < N) && (int'(rd_y) < N)) ? board[cell_addr(rd_x, rd_y)] : EMPTY;

endmodule

// File: tb/tb_board_engine.sv
// -----------------------------------------------------------------------------
// tb_board_engine
//   Drives two engines (N=8 as instance 0, N=6 as instance 1) against a
//   reference Othello model. Expected results are queued when a command is
//   issued and popped when done pulses; the board is compared through the
//   display read port after every command.
// -----------------------------------------------------------------------------
module tb_board_engine;
   import othello_pkg::*;

   localparam int XW = 3;   // $clog2(8) == $clog2(6) == 3

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic resetn;

   logic          cmd_valid [2];
   logic          cmd_ready [2];
   logic          cmd_write [2];
   logic [1:0]    side      [2];
   logic [XW-1:0] x         [2];
   logic [XW-1:0] y         [2];
   logic          done      [2];
   logic          legal     [2];
   logic [7:0]    dir       [2];
   logic [XW+2:0] flip_count[2];
   logic [XW-1:0] rd_x      [2];
   logic [XW-1:0] rd_y      [2];
   logic [1:0]    rd_q      [2];
   logic [2:0]    dbg_state [2];

   board_engine #(.N(8)) dut8 (
      .clock(clock), .resetn(resetn),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
      .side(side[0]), .x(x[0]), .y(y[0]),
      .done(done[0]), .legal(legal[0]), .dir(dir[0]), .flip_count(flip_count[0]),
      .rd_x(rd_x[0]), .rd_y(rd_y[0]), .rd_q(rd_q[0]), .dbg_state(dbg_state[0])
   );

   board_engine #(.N(6)) dut6 (
      .clock(clock), .resetn(resetn),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
      .side(side[1]), .x(x[1]), .y(y[1]),
      .done(done[1]), .legal(legal[1]), .dir(dir[1]), .flip_count(flip_count[1]),
      .rd_x(rd_x[1]), .rd_y(rd_y[1]), .rd_q(rd_q[1]), .dbg_state(dbg_state[1])
   );

   // ---------------- scoreboard state ----------------
   int          tests = 0;
   int          fails = 0;
   logic [14:0] exp_q[$];          // {legal, dir[7:0], flip_count[5:0]}
   int          mb [2][16][16];    // model board, [instance][y][x]
   int          dn_cnt [2] = '{0, 0};
   int          tdx [8] = '{ 0,  1, 1, 1, 0, -1, -1, -1};
   int          tdy [8] = '{-1, -1, 0, 1, 1,  1,  0, -1};

   always @(negedge clock) begin
      if (done[0] === 1'b1) dn_cnt[0]++;
      if (done[1] === 1'b1) dn_cnt[1]++;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int side_n(input int u);
      return (u == 0) ? 8 : 6;
   endfunction

   // ---------------- reference model ----------------
   task automatic model_init(input int u);
      int n, h;
      n = side_n(u);
      h = n / 2;
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++) mb[u][i][j] = 0;
      mb[u][h-1][h-1] = 2;
      mb[u][h-1][h]   = 3;
      mb[u][h][h-1]   = 3;
      mb[u][h][h]     = 2;
   endtask

   task automatic model_eval(input int u, input int s, input int px, input int py,
                             output logic [7:0] dm, output int nf);
      int n, o, qx, qy, c;
      n  = side_n(u);
      dm = 8'd0;
      nf = 0;
      o  = (s == 2) ? 3 : 2;
      if (mb[u][py][px] == 0) begin
         for (int k = 0; k < 8; k++) begin
            qx = px + tdx[k];
            qy = py + tdy[k];
            c  = 0;
            while (qx >= 0 && qx < n && qy >= 0 && qy < n && mb[u][qy][qx] == o) begin
               c++;
               qx += tdx[k];
               qy += tdy[k];
            end
            if (c > 0 && qx >= 0 && qx < n && qy >= 0 && qy < n && mb[u][qy][qx] == s) begin
               dm[k] = 1'b1;
               nf += c;
            end
         end
      end
   endtask

   task automatic model_apply(input int u, input int s, input int px, input int py);
      logic [7:0] dm;
      int nf, qx, qy, o;
      o = (s == 2) ? 3 : 2;
      model_eval(u, s, px, py, dm, nf);
      if (dm != 8'd0) begin
         for (int k = 0; k < 8; k++) begin
            if (dm[k]) begin
               qx = px + tdx[k];
               qy = py + tdy[k];
               while (mb[u][qy][qx] == o) begin
                  mb[u][qy][qx] = s;
                  qx += tdx[k];
                  qy += tdy[k];
               end
            end
         end
         mb[u][py][px] = s;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clock);
      resetn = 1'b0;
      @(posedge clock);
      #1 resetn = 1'b1;
      model_init(0);
      model_init(1);
   endtask

   task automatic cell_is(input int u, input int cx, input int cy, input int e, input string tag);
      rd_x[u] = XW'(cx);
      rd_y[u] = XW'(cy);
      #1;
      chk(tag, rd_q[u], e);
   endtask

   task automatic chk_board(input int u, input string tag);
      int n, bad;
      n   = side_n(u);
      bad = 0;
      for (int yy = 0; yy < n; yy++) begin
         for (int xx = 0; xx < n; xx++) begin
            rd_x[u] = XW'(xx);
            rd_y[u] = XW'(yy);
            #1;
            if (rd_q[u] !== 2'(mb[u][yy][xx])) bad++;
         end
      end
      chk(tag, bad, 0);
   endtask

   // Issue one command; expectation from the model (use_model) or given.
   task automatic do_cmd(input int u, input logic wr, input int s, input int px, input int py,
                         input logic use_model, input logic [14:0] exp_in, output int lat);
      logic [7:0]  dm;
      int          nf;
      logic [14:0] r;
      logic        got;
      model_eval(u, s, px, py, dm, nf);
      if (use_model) exp_q.push_back({|dm, dm, (wr && |dm) ? 6'(nf) : 6'd0});
      else           exp_q.push_back(exp_in);
      @(negedge clock);
      chk("ready_before_cmd", cmd_ready[u], 1);
      cmd_valid[u] = 1'b1;
      cmd_write[u] = wr;
      side[u]      = 2'(s);
      x[u]         = XW'(px);
      y[u]         = XW'(py);
      @(posedge clock);
      #1;
      cmd_valid[u] = 1'b0;
      x[u]         = XW'($urandom_range(0, 7));
      y[u]         = XW'($urandom_range(0, 7));
      side[u]      = 2'($urandom_range(2, 3));
      cmd_write[u] = 1'($urandom_range(0, 1));
      lat = 0;
      got = 1'b0;
      while (lat < 1000 && !got) begin
         @(negedge clock);
         lat++;
         if (done[u] === 1'b1) got = 1'b1;
      end
      chk("done_seen", got, 1);
      r = exp_q.pop_front();
      if (got) begin
         chk("legal", legal[u], r[14]);
         chk("dir", dir[u], r[13:6]);
         chk("flip_count", flip_count[u], r[5:0]);
      end
      if (wr) model_apply(u, s, px, py);
      chk_board(u, "board");
   endtask

   // ---------------- directed and random sequence ----------------
   initial begin : main
      int          lat, d0, s, n, nl, k, bound;
      int          lx [256];
      int          ly [256];
      logic [7:0]  dm;
      int          nf;
      logic [14:0] r;
      logic        got;

      resetn = 1'b0;
      for (int u = 0; u < 2; u++) begin
         cmd_valid[u] = 1'b0; cmd_write[u] = 1'b0; side[u] = 2'd2;
         x[u] = '0; y[u] = '0; rd_x[u] = '0; rd_y[u] = '0;
      end

      // 1: reset state
      do_reset();
      @(negedge clock);
      for (int u = 0; u < 2; u++) begin
         chk("reset_ready", cmd_ready[u], 1);
         chk("reset_done", done[u], 0);
         chk("reset_legal", legal[u], 0);
         chk("reset_dir", dir[u], 0);
         chk("reset_flip_count", flip_count[u], 0);
         chk_board(u, "reset_board");
      end
      cell_is(0, 3, 3, 2, "init_3_3");
      cell_is(0, 4, 3, 3, "init_4_3");
      cell_is(0, 3, 4, 3, "init_3_4");
      cell_is(0, 4, 4, 2, "init_4_4");
      cell_is(1, 2, 2, 2, "init6_2_2");
      cell_is(1, 3, 2, 3, "init6_3_2");

      // 2: PROBE side 3 at (2,3)
      do_cmd(0, 1'b0, 3, 2, 3, 1'b0, {1'b1, 8'h04, 6'd0}, lat);

      // 3: PLACE side 3 at (2,3), then PLACE side 2 at (2,2)
      do_cmd(0, 1'b1, 3, 2, 3, 1'b0, {1'b1, 8'h04, 6'd1}, lat);
      cell_is(0, 2, 3, 3, "place_target");
      cell_is(0, 3, 3, 3, "place_flipped");
      do_cmd(0, 1'b1, 2, 2, 2, 1'b0, {1'b1, 8'h08, 6'd1}, lat);
      cell_is(0, 3, 3, 2, "place2_flipped");

      // 4: occupied target and a cornered empty cell
      do_cmd(0, 1'b0, 2, 3, 3, 1'b0, {1'b0, 8'h00, 6'd0}, lat);
      chk("occupied_latency", lat, 3);
      do_cmd(0, 1'b0, 2, 0, 0, 1'b0, {1'b0, 8'h00, 6'd0}, lat);
      do_cmd(0, 1'b1, 3, 0, 0, 1'b0, {1'b0, 8'h00, 6'd0}, lat);

      // 5a: cmd_valid held with different x/y while busy
      model_eval(0, 3, 2, 1, dm, nf);
      exp_q.push_back({|dm, dm, 6'd0});
      d0 = dn_cnt[0];
      @(negedge clock);
      cmd_valid[0] = 1'b1; cmd_write[0] = 1'b0; side[0] = 2'd3; x[0] = 3'd2; y[0] = 3'd1;
      @(posedge clock);
      #1;
      x[0] = 3'd5; y[0] = 3'd5; side[0] = 2'd2;
      lat = 0;
      got = 1'b0;
      while (lat < 1000 && !got) begin
         @(negedge clock);
         lat++;
         if (done[0] === 1'b1) begin
            got = 1'b1;
            cmd_valid[0] = 1'b0;
         end
      end
      cmd_valid[0] = 1'b0;
      chk("held_done_seen", got, 1);
      r = exp_q.pop_front();
      chk("held_legal", legal[0], r[14]);
      chk("held_dir", dir[0], r[13:6]);
      repeat (20) @(negedge clock);
      chk("one_done_per_accept", dn_cnt[0] - d0, 1);
      chk_board(0, "held_board");

      // 5b: reset in the middle of FLIP
      do_reset();
      @(negedge clock);
      cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; side[0] = 2'd3; x[0] = 3'd2; y[0] = 3'd3;
      @(posedge clock);
      #1 cmd_valid[0] = 1'b0;
      bound = 0;
      got = 1'b0;
      while (bound < 200 && !got) begin
         @(negedge clock);
         bound++;
         if (dbg_state[0] === 3'(S_FLIP)) got = 1'b1;
      end
      chk("reached_flip", got, 1);
      resetn = 1'b0;
      @(posedge clock);
      #1 resetn = 1'b1;
      model_init(0);
      model_init(1);
      d0 = dn_cnt[0];
      @(negedge clock);
      chk("midflip_ready", cmd_ready[0], 1);
      chk("midflip_done", done[0], 0);
      chk("midflip_dir", dir[0], 0);
      chk("midflip_flip_count", flip_count[0], 0);
      chk_board(0, "midflip_board");
      repeat (20) @(negedge clock);
      chk("midflip_no_done", dn_cnt[0] - d0, 0);

      // 6: random games against the model, N=8 then N=6
      for (int u = 0; u < 2; u++) begin
         do_reset();
         n = side_n(u);
         s = 2;
         for (int mv = 0; mv < 45; mv++) begin
            nl = 0;
            for (int pass = 0; pass < 2 && nl == 0; pass++) begin
               if (pass == 1) s = (s == 2) ? 3 : 2;
               for (int yy = 0; yy < n; yy++)
                  for (int xx = 0; xx < n; xx++) begin
                     model_eval(u, s, xx, yy, dm, nf);
                     if (dm != 8'd0) begin
                        lx[nl] = xx;
                        ly[nl] = yy;
                        nl++;
                     end
                  end
            end
            if (nl == 0) begin
               do_reset();
               s = 2;
            end else if ($urandom_range(0, 4) == 0) begin
               do_cmd(u, 1'b0, s, int'($urandom_range(0, n - 1)), int'($urandom_range(0, n - 1)),
                      1'b1, 15'd0, lat);
            end else begin
               k = int'($urandom_range(0, nl - 1));
               do_cmd(u, 1'b1, s, lx[k], ly[k], 1'b1, 15'd0, lat);
               s = (s == 2) ? 3 : 2;
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
